// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared AXI definitions for the crossbar (arbiter, decoder, default slave).
//   - Response codes RESP_OKAY / RESP_DECERR
//   - Default widths for IDs, read data and burst length fields
// ---------------------------------------------------------------------------
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int AXI_ID_W   = 8;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_LEN_W  = 4;

endpackage : axi_pkg

// File: rtl/axi_default_slave.sv
// ---------------------------------------------------------------------------
// axi_default_slave
// Terminating slave for addresses that match no mapped slave. Handles one
// transaction at a time and completes it with DECERR:
//   - reads return ARLEN+1 zero-data beats, RLAST on the final one
//   - writes drain W beats until WLAST, then return a single B response
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   ARID/ARLEN/ARVALID/ARREADY     read address channel
//   RID/RDATA/RRESP/RLAST/RVALID/RREADY   read data channel
//   AWID/AWLEN/AWVALID/AWREADY     write address channel
//   WLAST/WVALID/WREADY            write data channel (data is discarded)
//   BID/BRESP/BVALID/BREADY        write response channel
//   err_cnt                        saturating count of accepted AR/AW
//                                  handshakes, only when the macro
//                                  DEFAULT_SLAVE_ERRCNT_EN is defined
// ---------------------------------------------------------------------------
module axi_default_slave
    import axi_pkg::*;
#(
    parameter int ID_W   = AXI_ID_W,
    parameter int DATA_W = AXI_DATA_W,
    parameter int LEN_W  = AXI_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    // read address
    input  logic [ID_W-1:0]   ARID,
    input  logic [LEN_W-1:0]  ARLEN,
    input  logic              ARVALID,
    output logic              ARREADY,
    // read data
    output logic [ID_W-1:0]   RID,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    // write address
    input  logic [ID_W-1:0]   AWID,
    input  logic [LEN_W-1:0]  AWLEN,
    input  logic              AWVALID,
    output logic              AWREADY,
    // write data
    input  logic              WLAST,
    input  logic              WVALID,
    output logic              WREADY,
    // write response
    output logic [ID_W-1:0]   BID,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY
`ifdef DEFAULT_SLAVE_ERRCNT_EN
    ,
    output logic [15:0]       err_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RDATA_ST = 2'd1,
        WDATA_ST = 2'd2,
        BRESP_ST = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [LEN_W-1:0] beat_cnt_reg, beat_cnt_next;
    logic [ID_W-1:0]  rid_reg, rid_next;
    logic [ID_W-1:0]  bid_reg, bid_next;

    logic ar_hs;
    logic aw_hs;

    // Read has priority over a simultaneous write request; both readies are
    // held low during reset so nothing is accepted while rst is asserted.
    assign ARREADY = (state_reg == IDLE) && !rst;
    assign AWREADY = (state_reg == IDLE) && !rst && !ARVALID;

    assign ar_hs = ARVALID && ARREADY;
    assign aw_hs = AWVALID && AWREADY;

    assign RVALID = (state_reg == RDATA_ST);
    assign RLAST  = RVALID && (beat_cnt_reg == '0);
    assign RID    = rid_reg;
    assign RDATA  = '0;
    assign RRESP  = RESP_DECERR;

    assign WREADY = (state_reg == WDATA_ST);

    assign BVALID = (state_reg == BRESP_ST);
    assign BID    = bid_reg;
    assign BRESP  = RESP_DECERR;

    always_comb begin
        state_next    = state_reg;
        beat_cnt_next = beat_cnt_reg;
        rid_next      = rid_reg;
        bid_next      = bid_reg;
        case (state_reg)
            IDLE: begin
                if (ar_hs) begin
                    rid_next      = ARID;
                    beat_cnt_next = ARLEN;
                    state_next    = RDATA_ST;
                end else if (aw_hs) begin
                    // AWLEN is kept in the beat counter for visibility only;
                    // WLAST alone ends the write burst.
                    bid_next      = AWID;
                    beat_cnt_next = AWLEN;
                    state_next    = WDATA_ST;
                end
            end
            RDATA_ST: begin
                if (RREADY) begin
                    if (beat_cnt_reg == '0) begin
                        state_next = IDLE;
                    end else begin
                        beat_cnt_next = beat_cnt_reg - LEN_W'(1);
                    end
                end
            end
            WDATA_ST: begin
                if (WVALID) begin
                    if (beat_cnt_reg != '0) begin
                        beat_cnt_next = beat_cnt_reg - LEN_W'(1);
                    end
                    if (WLAST) begin
                        state_next = BRESP_ST;
                    end
                end
            end
            BRESP_ST: begin
                if (BREADY) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            beat_cnt_reg <= '0;
            rid_reg      <= '0;
            bid_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            beat_cnt_reg <= beat_cnt_next;
            rid_reg      <= rid_next;
            bid_reg      <= bid_next;
        end
    end

`ifdef DEFAULT_SLAVE_ERRCNT_EN
    logic [15:0] err_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_reg <= '0;
        end else if ((ar_hs || aw_hs) && (err_cnt_reg != 16'hFFFF)) begin
            err_cnt_reg <= err_cnt_reg + 16'd1;
        end
    end

    assign err_cnt = err_cnt_reg;
`endif

endmodule : axi_default_slave
